mdu_iterative: RTL and testbench
================================

Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide execution unit in the backend.
- Responds to the decoder's MDU request: accepts one operation when the decoder flags an M-extension R-type instruction (funct7 = 0000001).
- Stalls the pipeline through `busy`, then returns the result with a one-cycle `done` pulse.
- Uses a shift-add multiplier and a restoring divider, one bit per cycle.

Parameters:
- XLEN, 32, operand and result width. Iteration count equals XLEN.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request strobe (decoder MDU flag qualified by a valid instruction in EX).
- function_3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operand_a  input  XLEN  rs1 value (forwarded).
- operand_b  input  XLEN  rs2 value (forwarded).
- flush  input  1  kill the in-flight operation (trap, mispredict).
- busy  output  1  operation in progress; the pipeline stalls EX while set.
- done  output  1  one-cycle pulse; `result` is valid in that cycle.
- result  output  XLEN  registered result; held until the next accepted start.

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, all internal registers 0. Reset mid-operation abandons it with no done pulse.
- States:
  - IDLE: ready for a new operation.
  - RUN: iterating; busy=1.
  - FIX: sign correction and result selection; busy=1.
  - DONE: done=1, busy=0, lasts one cycle.
- Accept: start=1 in IDLE or DONE latches function_3 and the operands. start in RUN or FIX is ignored.
- Normal path: cycle 0 accept; cycles 1..XLEN in RUN, one iteration per cycle with a counter counting XLEN-1 down to 0; cycle XLEN+1 in FIX; cycle XLEN+2 in DONE. Total latency from accept to done is XLEN+2 = 34 cycles.
- Multiply: operands converted to magnitudes per signedness, then 2*XLEN-bit shift-add.
  - MUL, MULH: a and b signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both unsigned.
  - FIX negates the 2*XLEN product when the operand signs differ (signed operands only).
  - MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Divide: restoring division on magnitudes.
  - Quotient is negated if the signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Fast path, no RUN or FIX: accept, then DONE in the next cycle (latency 1).
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return operand_a.
  - Signed overflow (a = 0x80000000, b = -1): DIV returns 0x80000000; REM returns 0.
  - Multiply with either operand zero returns 0.
- flush:
  - In RUN or FIX: return to IDLE next cycle; no done; result unchanged.
  - In DONE: done still shows this cycle, state goes to IDLE.
  - flush and start in the same cycle: flush wins, start is ignored.
- Back-to-back: start during DONE goes directly to RUN (or DONE on the fast path). done drops the next cycle and result is overwritten only when the new done occurs.
- All arithmetic is modulo 2^XLEN. No exceptions are raised.

Test Plan:
- MUL 7 * -3 (0x00000007, 0xFFFFFFFD) -> done exactly 34 cycles after accept, result 0xFFFFFFEB; busy high for cycles 1..33.
- MULH 0x80000000 * 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF * 0x00000002 -> 0xFFFFFFFF.
- DIV -20 / 3 -> 0xFFFFFFFA; REM -20 / 3 -> 0xFFFFFFFE; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF with done one cycle after accept. REMU 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- flush at cycle 10 of a DIVU -> busy low at cycle 11, no done, result keeps its prior value. A new start at cycle 12 completes normally with correct data.
- Reset asserted mid-RUN -> busy/done/result forced to 0 asynchronously. start during RUN is ignored. start in the DONE cycle is accepted back-to-back with a correct second result.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider, one bit per cycle.
// Special cases (divide by zero, signed overflow, multiply by zero) complete in one cycle.
module mdu_iterative #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      function_3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      fn_q, fn_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
  logic            negp_q, negp_d, negr_q, negr_d;

  // operand decode for a request arriving this cycle
  logic            is_div, a_sgn, b_sgn, a_neg, b_neg, fast;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    is_div   = function_3[2];
    a_sgn    = is_div ? ~function_3[0] : (function_3[1:0] != 2'b11);
    b_sgn    = is_div ? ~function_3[0] : ~function_3[1];
    a_neg    = a_sgn & operand_a[XLEN-1];
    b_neg    = b_sgn & operand_b[XLEN-1];
    a_mag    = a_neg ? -operand_a : operand_a;
    b_mag    = b_neg ? -operand_b : operand_b;
    fast     = 1'b0;
    fast_res = '0;
    if (is_div) begin
      if (operand_b == '0) begin
        fast     = 1'b1;
        fast_res = function_3[1] ? operand_a : '1;
      end else if (~function_3[0] && operand_a == MIN_INT && operand_b == '1) begin
        fast     = 1'b1;
        fast_res = function_3[1] ? '0 : MIN_INT;
      end
    end else if (operand_a == '0 || operand_b == '0) begin
      fast     = 1'b1;
      fast_res = '0;
    end
  end

  // one iteration step and the final sign correction
  logic [XLEN:0]     mul_sum, div_r;
  logic [XLEN-1:0]   div_sub, q_s, r_s, fix_res;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_s;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_r   = {hi_q, lo_q[XLEN-1]};
    div_ge  = div_r >= {1'b0, b_q};
    div_sub = div_r[XLEN-1:0] - b_q;
    prod_s  = negp_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    q_s     = negp_q ? -lo_q : lo_q;
    r_s     = negr_q ? -hi_q : hi_q;
    if (fn_q[2])               fix_res = fn_q[1] ? r_s : q_s;
    else if (fn_q[1:0] == 2'b00) fix_res = prod_s[XLEN-1:0];
    else                       fix_res = prod_s[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    negp_d   = negp_q;
    negr_d   = negr_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !flush) begin
          fn_d   = function_3;
          hi_d   = '0;
          lo_d   = a_mag;
          b_d    = b_mag;
          negp_d = a_neg ^ b_neg;
          negr_d = a_neg;
          cnt_d  = CW'(XLEN - 1);
          if (fast) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          // multiply shifts the product right; divide shifts the dividend left into the remainder
          if (fn_q[2]) begin
            hi_d = div_ge ? div_sub : div_r[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ge};
          end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
          end
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fn_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      negp_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      negp_q   <= negp_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_RUN) || (state_q == S_FIX);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: results, latency, fast paths, flush, reset and back-to-back issue.
module tb_mdu_iterative;
  logic        clk, rst_n, start, flush, busy, done;
  logic [2:0]  function_3;
  logic [31:0] operand_a, operand_b, result;
  int checks = 0;
  int failures = 0;

  mdu_iterative #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .function_3(function_3),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op from the current cycle (#1 after an edge); returns in the done cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] oa, input logic [31:0] ob,
                        input logic [31:0] exp, input int exp_lat, input string nm);
    int lat;
    logic busy_bad;
    function_3 = f; operand_a = oa; operand_b = ob; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 1; busy_bad = 1'b0;
    while (!done && lat < 200) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1 lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, exp_lat);
    end
    checks++;
    if (result !== exp) begin
      failures++; $display("FAIL %s result: got %h expected %h", nm, result, exp);
    end
    checks++;
    if (busy_bad || busy !== 1'b0) begin
      failures++; $display("FAIL %s busy: gap=%0b busy_at_done=%b expected high then 0", nm, busy_bad, busy);
    end
  endtask

  task automatic idle_step(input string nm);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s idle: done=%b busy=%b expected 0 0", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    function_3 = 3'd0; operand_a = '0; operand_b = '0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++; $display("FAIL reset: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_mul();
    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7x-3");
    idle_step("mul_7x-3");
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min");
    idle_step("mulh_min");
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_max");
    idle_step("mulhu_max");
    run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34, "mulhsu");
    idle_step("mulhsu");
    run_op(3'b000, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 1, "mul_zero");
    idle_step("mul_zero");
  endtask

  task automatic test_div();
    run_op(3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, "div_-20_3");
    idle_step("div_-20_3");
    run_op(3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, "rem_-20_3");
    idle_step("rem_-20_3");
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
    idle_step("divu_100_7");
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
    idle_step("remu_100_7");
  endtask

  task automatic test_fast_path();
    run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_by_zero");
    idle_step("div_by_zero");
    run_op(3'b111, 32'd5, 32'd0, 32'd5, 1, "remu_by_zero");
    idle_step("remu_by_zero");
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    idle_step("div_ovf");
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");
    idle_step("rem_ovf");
    run_op(3'b111, 32'd100, 32'd7, 32'd2, 34, "remu_prep");
    idle_step("remu_prep");
  endtask

  // Previous result is 2 (remu_prep); flush must leave it untouched.
  task automatic test_flush();
    logic saw_done;
    function_3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    saw_done = 1'b0;
    repeat (9) begin @(posedge clk); #1 if (done) saw_done = 1'b1; end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || saw_done || result !== 32'd2) begin
      failures++;
      $display("FAIL flush_run: busy=%b done=%b early_done=%b result=%h expected 0 0 0 00000002",
               busy, done, saw_done, result);
    end
    run_op(3'b101, 32'd1000, 32'd9, 32'd111, 34, "after_flush");
    // flush with start in DONE: done already seen, start dropped
    function_3 = 3'b100; operand_a = 32'd5; operand_b = 32'd0;
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1 flush = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd111) begin
      failures++; $display("FAIL flush_done: busy=%b done=%b result=%h expected 0 0 0000006f", busy, done, result);
    end
    idle_step("flush_done_next");
  endtask

  task automatic test_start_ignored();
    int lat;
    function_3 = 3'b101; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 1;
    repeat (3) begin @(posedge clk); #1 lat++; end
    function_3 = 3'b100; operand_a = 32'd5; operand_b = 32'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; lat++;
    while (!done && lat < 200) begin @(posedge clk); #1 lat++; end
    checks++;
    if (lat !== 34 || result !== 32'd14) begin
      failures++; $display("FAIL start_in_run: lat=%0d result=%h expected 34 0000000e", lat, result);
    end
  endtask

  // Entered in a DONE cycle: each new op is issued from the previous op's done cycle.
  task automatic test_back_to_back();
    run_op(3'b000, 32'd12, 32'd13, 32'd156, 34, "b2b_first");
    run_op(3'b110, 32'd17, 32'hFFFF_FFFB, 32'd2, 34, "b2b_rem");
    run_op(3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, "b2b_fast");
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 34, "b2b_mul");
    idle_step("b2b_end");
  endtask

  task automatic test_mid_reset();
    function_3 = 3'b000; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++; $display("FAIL mid_reset: busy=%b done=%b result=%h expected 0 0 0", busy, done, result);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) idle_step("post_reset");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 34, "mulh_after_reset");
    idle_step("mulh_after_reset");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast_path();
    test_flush();
    test_start_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
